// File: rtl/bcd_rtc_alarm.sv
// rtl/bcd_rtc_alarm.sv - six-digit BCD real-time clock with prescaler, validated load and sticky alarm
//
// Ports:
//   clk                     system clock, all state on posedge
//   reset                   synchronous, active-low
//   ena                     prescaler advance enable
//   load, ld_hh/mm/ss/pm    validated time load strobe and values
//   alarm_set, al_hh/mm/pm  validated alarm register load (alarm seconds fixed at 00)
//   alarm_en, alarm_ack     alarm match enable, sticky flag clear
//   hh, mm, ss, pm          registered BCD time (pm is 0 in 24-hour mode)
//   sec_tick                pulse alongside a tick-driven time update
//   load_err                pulse when a load or alarm_set is rejected
//   alarm_flag              sticky alarm indication
//   seg_*                   gfedcba seven-segment decode of each time digit
module bcd_rtc_alarm #(
    parameter int unsigned TICKS_PER_SEC  = 1,
    parameter bit          H24            = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       ld_pm,
    input  logic       alarm_set,
    input  logic [7:0] al_hh,
    input  logic [7:0] al_mm,
    input  logic       al_pm,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_tick,
    output logic       load_err,
    output logic       alarm_flag,
    output logic [6:0] seg_hh1,
    output logic [6:0] seg_hh0,
    output logic [6:0] seg_mm1,
    output logic [6:0] seg_mm0,
    output logic [6:0] seg_ss1,
    output logic [6:0] seg_ss0
);

    localparam int unsigned   PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PMAX   = PW'(TICKS_PER_SEC - 1);
    // 12:00:00 AM (midnight) in 12-hour mode, 00:00:00 in 24-hour mode
    localparam logic [7:0]    RST_HH = H24 ? 8'h00 : 8'h12;

    logic [PW-1:0] pcnt;
    logic          tick;
    logic [7:0]    al_hh_r;
    logic [7:0]    al_mm_r;
    logic          al_pm_r;

    logic [8:0]    ss_inc;
    logic [8:0]    mm_inc;
    logic [7:0]    hh_nxt;
    logic          pm_nxt;
    logic          ld_take;
    logic          ld_bad;
    logic          al_take;
    logic          al_bad;
    logic          match;

    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        logic ok;
        if (!digits_ok(v)) begin
            ok = 1'b0;
        end else if (H24) begin
            ok = (v <= 8'h23);
        end else begin
            ok = (v >= 8'h01) && (v <= 8'h12);
        end
        return ok;
    endfunction

    function automatic logic min_ok(input logic [7:0] v);
        return digits_ok(v) && (v <= 8'h59);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // {carry, next} for a 00..59 BCD field
    function automatic logic [8:0] inc60(input logic [7:0] v);
        logic [8:0] r;
        if (v == 8'h59) begin
            r = {1'b1, 8'h00};
        end else begin
            r = {1'b0, bcd_inc(v)};
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    assign tick = ena && (pcnt == PMAX);

    // Next time value if a tick is applied this cycle
    always_comb begin
        ss_inc = inc60(ss);
        mm_inc = ss_inc[8] ? inc60(mm) : {1'b0, mm};
        hh_nxt = hh;
        pm_nxt = pm;
        if (mm_inc[8]) begin
            if (H24) begin
                hh_nxt = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
            end else if (hh == 8'h12) begin
                // 12 -> 01 keeps the half of the day
                hh_nxt = 8'h01;
            end else begin
                hh_nxt = bcd_inc(hh);
                if (hh == 8'h11) begin
                    pm_nxt = ~pm;
                end
            end
        end
        if (H24) begin
            pm_nxt = 1'b0;
        end
    end

    always_comb begin
        ld_take = load && hour_ok(ld_hh) && min_ok(ld_mm) && min_ok(ld_ss);
        ld_bad  = load && !ld_take;
        al_take = alarm_set && hour_ok(al_hh) && min_ok(al_mm);
        al_bad  = alarm_set && !al_take;
        // Only a tick can raise the alarm; an accepted load overrides the tick
        match   = tick && !ld_take && alarm_en &&
                  (ss_inc[7:0] == 8'h00) &&
                  (mm_inc[7:0] == al_mm_r) &&
                  (hh_nxt == al_hh_r) &&
                  (H24 || (pm_nxt == al_pm_r));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hh         <= RST_HH;
            mm         <= 8'h00;
            ss         <= 8'h00;
            pm         <= 1'b0;
            pcnt       <= '0;
            al_hh_r    <= RST_HH;
            al_mm_r    <= 8'h00;
            al_pm_r    <= 1'b0;
            alarm_flag <= 1'b0;
            sec_tick   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (ld_take) begin
                hh   <= ld_hh;
                mm   <= ld_mm;
                ss   <= ld_ss;
                pm   <= H24 ? 1'b0 : ld_pm;
                pcnt <= '0;
            end else begin
                if (ena) begin
                    pcnt <= tick ? '0 : pcnt + 1'b1;
                end
                if (tick) begin
                    ss       <= ss_inc[7:0];
                    mm       <= mm_inc[7:0];
                    hh       <= hh_nxt;
                    pm       <= pm_nxt;
                    sec_tick <= 1'b1;
                end
            end

            if (al_take) begin
                al_hh_r <= al_hh;
                al_mm_r <= al_mm;
                al_pm_r <= H24 ? 1'b0 : al_pm;
            end

            load_err <= ld_bad || al_bad;

            // A new match wins over a coincident acknowledge
            if (match) begin
                alarm_flag <= 1'b1;
            end else if (alarm_ack) begin
                alarm_flag <= 1'b0;
            end
        end
    end

    assign seg_hh1 = seg7(hh[7:4]);
    assign seg_hh0 = seg7(hh[3:0]);
    assign seg_mm1 = seg7(mm[7:4]);
    assign seg_mm0 = seg7(mm[3:0]);
    assign seg_ss1 = seg7(ss[7:4]);
    assign seg_ss0 = seg7(ss[3:0]);

endmodule

// File: tb/tb_bcd_rtc_alarm.sv
// tb/tb_bcd_rtc_alarm.sv - self-checking bench for bcd_rtc_alarm (12h/T=4 and 24h/T=1/active-low instances)
module tb_bcd_rtc_alarm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ena, load, ld_pm, alarm_set, al_pm, alarm_en, alarm_ack;
    logic [7:0] ld_hh, ld_mm, ld_ss, al_hh, al_mm;

    logic [7:0]       hh0, mm0, ss0, hh1, mm1, ss1;
    logic             pm0, pm1, tk0, tk1, er0, er1, fl0, fl1;
    logic [5:0][6:0]  sg0, sg1;

    bcd_rtc_alarm #(.TICKS_PER_SEC(4), .H24(1'b0), .SEG_ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .reset(reset), .ena(ena), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .alarm_set(alarm_set), .al_hh(al_hh), .al_mm(al_mm), .al_pm(al_pm),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hh(hh0), .mm(mm0), .ss(ss0), .pm(pm0),
        .sec_tick(tk0), .load_err(er0), .alarm_flag(fl0),
        .seg_hh1(sg0[5]), .seg_hh0(sg0[4]), .seg_mm1(sg0[3]),
        .seg_mm0(sg0[2]), .seg_ss1(sg0[1]), .seg_ss0(sg0[0])
    );

    bcd_rtc_alarm #(.TICKS_PER_SEC(1), .H24(1'b1), .SEG_ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .reset(reset), .ena(ena), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .alarm_set(alarm_set), .al_hh(al_hh), .al_mm(al_mm), .al_pm(al_pm),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hh(hh1), .mm(mm1), .ss(ss1), .pm(pm1),
        .sec_tick(tk1), .load_err(er1), .alarm_flag(fl1),
        .seg_hh1(sg1[5]), .seg_hh0(sg1[4]), .seg_mm1(sg1[3]),
        .seg_mm0(sg1[2]), .seg_ss1(sg1[1]), .seg_ss0(sg1[0])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: time kept as seconds since midnight
    int  m_secs [2];
    int  m_pc   [2];
    int  m_asec [2];
    bit  m_flag [2];
    bit  m_tick [2];
    bit  m_err  [2];
    int  m_t    [2] = '{4, 1};
    bit  m_h24  [2] = '{1'b0, 1'b1};
    bit  m_inv  [2] = '{1'b0, 1'b1};

    logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        bit rst, en, ld; logic [7:0] lh, lm, ls; bit lp;
        bit as; logic [7:0] ah, am; bit ap, aen, ack;
        logic [7:0] eh, em, es; bit ep, etk, eer, efl;
    } vec_t;
    vec_t vecs[$];

    function automatic bit dig_ok(logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int b2i(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(int x);
        logic [7:0] r;
        r[7:4] = 4'(x / 10);
        r[3:0] = 4'(x % 10);
        return r;
    endfunction

    // Seconds since midnight, or -1 for an illegal time
    function automatic int to_secs(bit h24, logic [7:0] h, logic [7:0] m, logic [7:0] s, logic p);
        int hi, mi, si, r;
        r = -1;
        if (dig_ok(h) && dig_ok(m) && dig_ok(s)) begin
            hi = b2i(h); mi = b2i(m); si = b2i(s);
            if (mi <= 59 && si <= 59) begin
                if (h24 && hi <= 23) begin
                    r = hi * 3600 + mi * 60 + si;
                end else if (!h24 && hi >= 1 && hi <= 12) begin
                    r = ((hi % 12) + (p ? 12 : 0)) * 3600 + mi * 60 + si;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_ref(logic [3:0] n, bit inv);
        logic [6:0] v;
        v = (n > 4'd9) ? 7'h00 : seg_tbl[n];
        return inv ? ~v : v;
    endfunction

    task automatic model_step(int k);
        int ls, as;
        bit tk, match;
        if (!reset) begin
            m_secs[k] = 0; m_pc[k] = 0; m_asec[k] = 0;
            m_flag[k] = 0; m_tick[k] = 0; m_err[k] = 0;
        end else begin
            ls = load      ? to_secs(m_h24[k], ld_hh, ld_mm, ld_ss, ld_pm) : -1;
            as = alarm_set ? to_secs(m_h24[k], al_hh, al_mm, 8'h00, al_pm) : -1;
            tk = ena && (m_pc[k] == m_t[k] - 1);
            match = 0;
            m_err[k] = (load && ls < 0) || (alarm_set && as < 0);
            if (ls >= 0) begin
                m_secs[k] = ls; m_pc[k] = 0; m_tick[k] = 0;
            end else begin
                if (ena) m_pc[k] = tk ? 0 : m_pc[k] + 1;
                m_tick[k] = tk;
                if (tk) begin
                    m_secs[k] = (m_secs[k] + 1) % 86400;
                    match = alarm_en && (m_secs[k] == m_asec[k]);
                end
            end
            if (match) m_flag[k] = 1;
            else if (alarm_ack) m_flag[k] = 0;
            if (as >= 0) m_asec[k] = as;
        end
    endtask

    task automatic check_dut(int k);
        logic [7:0]  eh, em, es;
        logic        ep;
        logic [27:0] got, exp;
        logic [41:0] gsg, esg;
        int h;
        h  = m_secs[k] / 3600;
        em = i2b((m_secs[k] / 60) % 60);
        es = i2b(m_secs[k] % 60);
        if (m_h24[k]) begin
            eh = i2b(h); ep = 1'b0;
        end else begin
            eh = i2b((h % 12 == 0) ? 12 : h % 12); ep = (h >= 12);
        end
        exp = {eh, em, es, ep, m_tick[k], m_err[k], m_flag[k]};
        got = (k == 0) ? {hh0, mm0, ss0, pm0, tk0, er0, fl0} : {hh1, mm1, ss1, pm1, tk1, er1, fl1};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model u%0d cyc=%0d got hh:mm:ss/pm/tick/err/flag=%h:%h:%h/%b/%b/%b/%b required=%h:%h:%h/%b/%b/%b/%b",
                     k, cyc, got[27:20], got[19:12], got[11:4], got[3], got[2], got[1], got[0],
                     eh, em, es, ep, m_tick[k], m_err[k], m_flag[k]);
        end
        esg = {seg_ref(eh[7:4], m_inv[k]), seg_ref(eh[3:0], m_inv[k]),
               seg_ref(em[7:4], m_inv[k]), seg_ref(em[3:0], m_inv[k]),
               seg_ref(es[7:4], m_inv[k]), seg_ref(es[3:0], m_inv[k])};
        gsg = (k == 0) ? sg0 : sg1;
        total++;
        if (gsg !== esg) begin
            bad++;
            $display("FAIL seg u%0d cyc=%0d got=%h required=%h", k, cyc, gsg, esg);
        end
    endtask

    task automatic drive(bit r, bit e, bit l, logic [7:0] lh, logic [7:0] lm, logic [7:0] ls, bit lp,
                         bit as, logic [7:0] ah, logic [7:0] am, bit ap, bit aen, bit ack);
        reset = r; ena = e; load = l; ld_hh = lh; ld_mm = lm; ld_ss = ls; ld_pm = lp;
        alarm_set = as; al_hh = ah; al_mm = am; al_pm = ap; alarm_en = aen; alarm_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        cyc++;
    endtask

    task automatic expect_val(string name, logic [7:0] got, logic [7:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic add(bit rst, bit en, bit ld, logic [7:0] lh, logic [7:0] lm, logic [7:0] ls, bit lp,
                       bit as, logic [7:0] ah, logic [7:0] am, bit ap, bit aen, bit ack,
                       logic [7:0] eh, logic [7:0] em, logic [7:0] es, bit ep, bit etk, bit eer, bit efl);
        vec_t v;
        v.rst = rst; v.en = en; v.ld = ld; v.lh = lh; v.lm = lm; v.ls = ls; v.lp = lp;
        v.as = as; v.ah = ah; v.am = am; v.ap = ap; v.aen = aen; v.ack = ack;
        v.eh = eh; v.em = em; v.es = es; v.ep = ep; v.etk = etk; v.eer = eer; v.efl = efl;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] rnd_field(int maxv);
        logic [7:0] r;
        if ($urandom_range(0, 3) != 0) r = i2b($urandom_range(0, maxv));
        else r = 8'($urandom_range(0, 255));
        return r;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_secs[k] = 0; m_pc[k] = 0; m_asec[k] = 0; m_flag[k] = 0; m_tick[k] = 0; m_err[k] = 0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Expected columns describe u0 (TICKS_PER_SEC=4, 12-hour)
        //   rst en ld  lh     lm     ls     lp as ah     am     ap aen ack  eh     em     es     ep tk er fl
        add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h01, 0, 1, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h01, 0, 0, 0, 0);
        add(1, 0, 1, 8'h11, 8'h59, 8'h59, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h11, 8'h59, 8'h59, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h00, 1, 1, 0, 0);
        add(1, 0, 1, 8'h12, 8'h59, 8'h59, 1, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h59, 8'h59, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h12, 8'h59, 8'h59, 1, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h01, 8'h00, 8'h00, 1, 1, 0, 0);
        add(1, 0, 1, 8'h24, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h01, 8'h00, 8'h00, 1, 0, 1, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h01, 8'h00, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0);
        add(1, 1, 1, 8'h01, 8'h5A, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0,  8'h01, 8'h00, 8'h01, 1, 1, 1, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h01, 8'h00, 8'h01, 1, 0, 0, 0);
        add(1, 0, 1, 8'h07, 8'h29, 8'h59, 0, 1, 8'h07, 8'h30, 0, 1, 0,  8'h07, 8'h29, 8'h59, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h07, 8'h29, 8'h59, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0,  8'h07, 8'h30, 8'h00, 0, 1, 0, 1);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 1,  8'h07, 8'h30, 8'h00, 0, 0, 0, 0);
        add(1, 0, 1, 8'h07, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0,  8'h07, 8'h30, 8'h00, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0,  8'h07, 8'h30, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h07, 8'h30, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h07, 8'h30, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 8'h07, 8'h29, 8'h59, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h01, 0, 1, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h07, 8'h60, 0, 0, 0,  8'h12, 8'h00, 8'h01, 0, 0, 1, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h00, 8'h01, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].lh, vecs[i].lm, vecs[i].ls, vecs[i].lp,
                  vecs[i].as, vecs[i].ah, vecs[i].am, vecs[i].ap, vecs[i].aen, vecs[i].ack);
            step();
            total++;
            if ({hh0, mm0, ss0, pm0, tk0, er0, fl0} !==
                {vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ep, vecs[i].etk, vecs[i].eer, vecs[i].efl}) begin
                bad++;
                $display("FAIL tbl[%0d] got=%h:%h:%h pm=%b tk=%b err=%b flag=%b required=%h:%h:%h pm=%b tk=%b err=%b flag=%b",
                         i, hh0, mm0, ss0, pm0, tk0, er0, fl0,
                         vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ep, vecs[i].etk, vecs[i].eer, vecs[i].efl);
            end
            if (i == 4) expect_val("tbl_seg_ss0_after_first_tick", {1'b0, sg0[0]}, 8'h06);
        end

        // 24-hour rollover and out-of-range hour on u1
        drive(1, 0, 1, 8'h23, 8'h59, 8'h59, 0, 0, 8'h00, 8'h00, 0, 0, 0); step();
        expect_val("u1_load_235959_hh", hh1, 8'h23);
        drive(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0); step();
        expect_val("u1_rollover_hhmmss", {hh1 | mm1 | ss1}, 8'h00);
        expect_val("u1_rollover_pm_tick", {6'd0, pm1, tk1}, 8'h01);
        drive(1, 0, 1, 8'h24, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0); step();
        expect_val("u1_hh24_load_err", {7'd0, er1}, 8'h01);
        expect_val("u1_hh24_time_kept_ss", ss1, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0); step();
        expect_val("u1_load_err_one_cycle", {7'd0, er1}, 8'h00);

        // Match coincident with ack keeps the flag; alarm_en low does not clear it
        drive(1, 0, 1, 8'h04, 8'h59, 8'h59, 0, 1, 8'h05, 8'h00, 0, 1, 0); step();
        drive(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 1); step();
        expect_val("u1_match_with_ack_flag", {7'd0, fl1}, 8'h01);
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0); step();
        expect_val("u1_flag_held_alarm_en_low", {7'd0, fl1}, 8'h01);
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1); step();
        expect_val("u1_flag_cleared_by_ack", {7'd0, fl1}, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 299) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 11) == 0,
                  rnd_field(24), rnd_field(59), rnd_field(59), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0,
                  rnd_field(24), rnd_field(59), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) == 0);
            // Steer some loads just before the alarm to exercise matching
            if ($urandom_range(0, 39) == 0) begin
                load = 1'b1; alarm_set = 1'b1;
                al_hh = 8'h06; al_mm = 8'h15; al_pm = 1'b0;
                ld_hh = 8'h06; ld_mm = 8'h14; ld_ss = 8'h57; ld_pm = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_rtc_alarm.md
Name: bcd_rtc_alarm

Overview:
Parametrised successor to the 12-hour BCD clock. Adds a configurable seconds prescaler, a compile-time 12/24-hour mode, synchronous time load with BCD validation, and an alarm comparator with a sticky flag. Seven-segment decode covers all six digits. It sits between the system clock domain and the display/alarm logic, and is the single timekeeping source.

Parameters:
TICKS_PER_SEC, 1, number of enabled clk cycles per second increment (>=1).
H24, 0, 0 = 12-hour with pm; 1 = 24-hour, pm tied 0.
SEG_ACTIVE_LOW, 0, 1 inverts all seg_* outputs.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset.
ena  in  1  count enable; prescaler advances only when high.
load  in  1  time load strobe (single cycle).
ld_hh, ld_mm, ld_ss  in  8 each  BCD load values.
ld_pm  in  1  load pm value; ignored when H24=1.
alarm_set  in  1  alarm register load strobe.
al_hh, al_mm  in  8 each  BCD alarm time; alarm seconds are fixed at 00.
al_pm  in  1  alarm pm; ignored when H24=1.
alarm_en  in  1  enables alarm matching.
alarm_ack  in  1  clears alarm_flag.
hh, mm, ss  out  8 each  BCD time, registered.
pm  out  1  registered; constant 0 when H24=1.
sec_tick  out  1  one-cycle pulse in the cycle ss updates because of a tick.
load_err  out  1  one-cycle pulse when a load/alarm_set is rejected.
alarm_flag  out  1  sticky alarm indication.
seg_hh1, seg_hh0, seg_mm1, seg_mm0, seg_ss1, seg_ss0  out  7 each  gfedcba, combinational from hh/mm/ss.

Behaviour:
- Reset (reset==0 at posedge) has highest priority:
  - Time: H24=0 gives 12:00:00, pm=0. H24=1 gives 00:00:00.
  - Prescaler = 0.
  - Alarm regs = reset time value; alarm_flag, sec_tick, load_err = 0.
- Prescaler: tick = ena && (pcnt == TICKS_PER_SEC-1). On tick pcnt becomes 0, otherwise pcnt+1 while ena. With ena low, pcnt holds. TICKS_PER_SEC=1 gives a tick on every ena cycle.
- On tick, BCD increment:
  - ss: 59 -> 00 with carry into mm; mm: 59 -> 00 with carry into hh.
  - H24=0: 11 -> 12 toggles pm; 12 -> 01 does not toggle pm. 12 AM is midnight.
  - H24=1: 23:59:59 -> 00:00:00.
  - Low digit 9 -> 0 with carry into the high digit.
  - sec_tick = 1 in the same cycle the register updates (registered alongside ss).
- Load (reset high, load high):
  - Validation: each digit <= 9; mm and ss <= 59; hh within 01..12 (H24=0) or 00..23 (H24=1).
  - Valid: hh/mm/ss/pm take the ld_* values at the posedge, pcnt = 0, and any coincident tick is discarded.
  - Invalid: time and pcnt are unchanged (the tick still applies) and load_err pulses for 1 cycle.
- alarm_set uses the same validation rules on al_hh/al_mm; on rejection load_err pulses. load and alarm_set may occur in the same cycle and are validated independently; load_err is asserted if either is rejected.
- Alarm match:
  - alarm_flag sets at the posedge where a tick moves the time into hh==al_hh, mm==al_mm, ss==00 (and pm==al_pm when H24=0) while alarm_en=1.
  - Entering the matching time via load does not set the flag.
  - The flag stays set until a cycle with alarm_ack=1 and no new match; a simultaneous match and ack leaves the flag set.
  - alarm_en=0 blocks new sets but does not clear the flag.
- Seven-segment encoding (active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; nibble > 9 gives 00. SEG_ACTIVE_LOW=1 inverts all outputs. Leading zeros are displayed.
- Latency: tick to time update is 1 cycle (registered); seg_* follow the registers combinationally.

Test Plan:
- Reset then ena=1, TICKS_PER_SEC=4 -> sec_tick every 4th cycle; ss 00->01 at cycle 4; seg_ss0 = 06.
- H24=0: load 11:59:59 pm=0, one tick -> 12:00:00, pm=1; load 12:59:59, one tick -> 01:00:00 with pm unchanged.
- H24=1: load 23:59:59, one tick -> 00:00:00, pm=0; load hh=24 -> load_err pulse, time unchanged.
- Invalid BCD: load mm=8'h5A -> load_err=1 for 1 cycle; a coincident valid tick still advances ss.
- Alarm 07:30 AM, alarm_en=1, load 07:29:59, tick -> alarm_flag=1; alarm_ack -> flag 0; load 07:30:00 -> flag stays 0.
- Reset asserted mid-count with load=1 in the same cycle -> reset values win and the prescaler restarts from 0.
